// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB/I2C target register file: FSM state
// encoding, bus direction/acknowledge bit values and the default address.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } sccb_state_e;

  localparam logic SCCB_WRITE = 1'b0;
  localparam logic SCCB_READ  = 1'b1;
  localparam logic ACK        = 1'b0;
  localparam logic NACK       = 1'b1;

  localparam logic [6:0] SCCB_DEFAULT_ADDR = 7'h21;

endpackage

// File: rtl/sccb_target_regfile_sync.sv
// Bus front end: 2-flop synchronizers on SCL/SDA, optional 3-sample majority
// filter (macro I2C_TARGET_GLITCH_FILTER_EN), and registered edge / START /
// STOP detection. Pin-to-event latency is 3 clk (5 clk with the filter).
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // Bit 1 carries SCL, bit 0 carries SDA throughout.
  logic [1:0] s1_q, s2_q, hist_q, cln;

  // Metastability synchronizers; reset to the idle (released) bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= {scl_i, sda_i};
      s2_q <= s1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] p0_q, p1_q, maj_q;

  // Majority of three consecutive samples rejects single-clock pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q  <= '1;
      p1_q  <= '1;
      maj_q <= '1;
    end else begin
      p0_q  <= s2_q;
      p1_q  <= p0_q;
      maj_q <= (s2_q & p0_q) | (s2_q & p1_q) | (p0_q & p1_q);
    end
  end

  assign cln = maj_q;
`else
  assign cln = s2_q;
`endif

  // Edge and condition detection; START/STOP only qualify with SCL stably high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      hist_q    <= cln;
      scl_rise  <= cln[1] & ~hist_q[1];
      scl_fall  <= ~cln[1] & hist_q[1];
      start_det <= cln[1] & hist_q[1] & ~cln[0] & hist_q[0];
      stop_det  <= cln[1] & hist_q[1] & cln[0] & ~hist_q[0];
      sda_s     <= cln[0];
    end
  end

endmodule

// File: rtl/sccb_target_regfile.sv
// SCCB/I2C target modelling a camera-style 8-bit register file: address
// match, sub-address write bursts and sequential reads with pointer wrap.
// Optional input glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module sccb_target_regfile
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDR = SCCB_DEFAULT_ADDR,
  parameter int unsigned MEM_DEPTH   = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_nack,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int unsigned AW       = $clog2(MEM_DEPTH);
  localparam logic [7:0]  PTR_MASK = 8'(MEM_DEPTH - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  sccb_state_e state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, ptr_q, ptr_d;
  logic [7:0]  waddr_q, waddr_d, wdata_q, wdata_d;
  logic        oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
  logic        wstb_q, wstb_d, nack_q, nack_d;
  logic        mem_we;
  logic [7:0]  sbyte, rbyte;
  logic [7:0]  mem [MEM_DEPTH];

  assign sbyte    = {shift_q[6:0], sda_s};
  assign rbyte    = mem[ptr_q[AW-1:0]];
  assign dbg_data = mem[dbg_addr[AW-1:0]];

  // Register file storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q[AW-1:0]] <= sbyte;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      wstb_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      wstb_q  <= wstb_d;
      nack_q  <= nack_d;
    end
  end

  // Protocol FSM: bits sampled on SCL rise, SDA drive changed on SCL fall.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    wstb_d  = 1'b0;
    nack_d  = 1'b0;
    mem_we  = 1'b0;
    if (start_det) begin
      state_d = ST_ADDR;
      bit_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      bit_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_SUB, ST_WDATA: begin
          if (scl_rise) begin
            shift_d = sbyte;
            bit_d   = 4'(bit_q + 4'd1);
            if (state_q == ST_WDATA && bit_q == 4'd7) begin
              mem_we  = 1'b1;
              wstb_d  = 1'b1;
              waddr_d = ptr_q;
              wdata_d = sbyte;
              ptr_d   = 8'(ptr_q + 8'd1) & PTR_MASK;
            end
          end else if (scl_fall && bit_q == 4'd8) begin
            bit_d = '0;
            oe_d  = 1'b1;
            if (state_q == ST_SUB) begin
              ptr_d   = shift_q & PTR_MASK;
              state_d = ST_SUB_ACK;
            end else if (state_q == ST_WDATA) begin
              state_d = ST_WDATA_ACK;
            end else if (shift_q[7:1] == DEVICE_ADDR) begin
              state_d = ST_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
            end else begin
              state_d = ST_IGNORE;
              oe_d    = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_d = '0;
            if (rw_q == SCCB_WRITE) begin
              state_d = ST_SUB;
              oe_d    = 1'b0;
            end else begin
              state_d = ST_RDATA;
              shift_d = rbyte;
              oe_d    = ~rbyte[7];
            end
          end
        end
        ST_SUB_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = ST_WDATA;
            oe_d    = 1'b0;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_d = 4'(bit_q + 4'd1);
          end else if (scl_fall) begin
            if (bit_q == 4'd8) begin
              bit_d   = '0;
              oe_d    = 1'b0;
              ptr_d   = 8'(ptr_q + 8'd1) & PTR_MASK;
              state_d = ST_RACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        ST_RACK: begin
          // A NACK ends the read at the sampling edge; a later fall means ACK.
          if (scl_rise && sda_s == NACK) begin
            nack_d  = 1'b1;
            state_d = ST_IGNORE;
          end else if (scl_fall) begin
            state_d = ST_RDATA;
            shift_d = rbyte;
            oe_d    = ~rbyte[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wstb_q;
  assign wr_addr   = waddr_q;
  assign wr_data   = wdata_q;
  assign rd_nack   = nack_q;

endmodule
